rr_arb_mux: RTL and testbench

- Parametrised successor of the fixed 8:1 select mux: N-input, WIDTH-bit streaming multiplexer with valid/ready handshakes on every port.
- Round-robin arbitration with optional packet locking, plus a legacy forced-select mode that reproduces static select-line behaviour.
- Registered output stage gives one cycle of latency.
- Sits between multiple producer channels (per-app memory/request streams) and a single shared consumer.

---
 rtl/rr_arb_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/rr_arb_mux.sv | 182 ++++++++++++++++++
 tb/tb_rr_arb_mux.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg
// Shared definitions for the round-robin arbitrating stream multiplexer:
//   - state_e : packet-lock FSM states (ST_IDLE, ST_LOCKED)
//   - MIN_N / MAX_N : legal range of the channel count parameter N
package rr_arb_mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int MIN_N = 2;
    localparam int MAX_N = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin priority search. Returns the first
// requesting channel at or above ptr_i, wrapping from N-1 back to 0.
// Ports:
//   req_i         in  N      request vector (one bit per channel)
//   ptr_i         in  SEL_W  channel with highest priority this cycle
//   en_i          in  1      0 forces "no grant"
//   grant_o       out SEL_W  granted channel index (0 when no grant)
//   grant_valid_o out 1      a grant was found
module rr_arbiter #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] grant_o,
    output logic             grant_valid_o
);

    localparam logic [SEL_W:0] N_W = (SEL_W+1)'(N);

    // Two copies of the request vector side by side let the search run
    // linearly from ptr_i without explicit wrap handling; an index past
    // N-1 folds back by subtracting N.
    logic [2*N-1:0] req_dbl;
    logic [SEL_W:0] idx;

    assign req_dbl = {req_i, req_i};

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        // Descending loop: the lowest offset from ptr_i is written last
        // and therefore wins.
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_i} + (SEL_W+1)'(i);
            if (en_i && req_dbl[idx]) begin
                grant_valid_o = 1'b1;
                grant_o       = (idx >= N_W) ? SEL_W'(idx - N_W) : SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux
// N-input, WIDTH-bit valid/ready stream multiplexer with round-robin
// arbitration, a forced-select mode reproducing static select lines, and a
// registered output stage (one cycle of latency).
//
// Handshake: a beat moves on any port when valid && ready are both high at
// a rising clock edge. in_ready is combinational: only the granted channel
// sees ready, and only when the output register is empty or being drained
// (load = !out_valid || out_ready). Once out_valid is high, out_data,
// out_last and out_src stay stable until out_ready accepts the beat.
//
// Build option RR_ARB_MUX_PKT_LOCK_EN: when defined, an IDLE/LOCKED FSM keeps
// the grant on one channel from its first beat until its in_last beat, and
// the round-robin pointer only advances at packet end. When undefined,
// arbitration is per beat and in_last is only forwarded to out_last.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/valid/last  per-channel input stream (in_data unpacked [N-1:0])
//   in_ready            per-channel ready (combinational, 0 during reset)
//   force_en, force_sel static select mode and its channel
//   out_data/valid/last registered output beat
//   out_src             channel that supplied the current output beat
//   out_ready           consumer ready
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data [N-1:0],
    input  logic [N-1:0]     in_valid,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [SEL_W-1:0] out_src,
    input  logic             out_ready
);

    if (N < MIN_N || N > MAX_N) begin : g_bad_n
        $error("rr_arb_mux: N must lie in 2..32");
    end

    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [SEL_W-1:0] out_src_q;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             xfer;
    logic             locked;
    logic [SEL_W-1:0] lock_ch;
    logic             beat_forced;
    logic             ends_arb;
    logic             force_ok;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    state_e           state_q;
    logic [SEL_W-1:0] lock_ch_q;
    logic             lock_forced_q;

    assign locked  = (state_q == ST_LOCKED);
    assign lock_ch = lock_ch_q;
    // force_en/force_sel changes are ignored mid-packet, so the packet's
    // own mode decides whether its last beat may move the pointer.
    assign beat_forced = locked ? lock_forced_q : force_en;
    assign ends_arb    = in_last[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lock_ch_q     <= '0;
            lock_forced_q <= 1'b0;
        end else if (xfer) begin
            case (state_q)
                ST_IDLE: begin
                    if (!in_last[grant]) begin
                        state_q       <= ST_LOCKED;
                        lock_ch_q     <= grant;
                        lock_forced_q <= force_en;
                    end
                end
                ST_LOCKED: begin
                    if (in_last[grant]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    assign locked      = 1'b0;
    assign lock_ch     = '0;
    assign beat_forced = force_en;
    assign ends_arb    = 1'b1;
`endif

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i         (in_valid),
        .ptr_i         (ptr_q),
        .en_i          (!locked && !force_en),
        .grant_o       (arb_grant),
        .grant_valid_o (arb_valid)
    );

    // force_sel values >= N select nothing (reachable when N is not a
    // power of two).
    assign force_ok = (int'(force_sel) < N) && in_valid[force_sel];

    always_comb begin
        grant       = arb_grant;
        grant_valid = arb_valid;
        if (locked) begin
            grant       = lock_ch;
            grant_valid = in_valid[lock_ch];
        end else if (force_en) begin
            grant       = force_sel;
            grant_valid = force_ok;
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = load && grant_valid && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && ends_arb && !beat_forced) begin
            ptr_d = (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            // With load high the register either takes a new beat or
            // empties; without load it holds the stalled beat.
            if (load) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    out_data_q <= in_data[grant];
                    out_last_q <= in_last[grant];
                    out_src_q  <= grant;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  localparam int WIDTH = 64;
  localparam int N     = 8;
  localparam int SEL_W = $clog2(N);
  localparam int BW    = SEL_W + 1 + WIDTH;
  localparam int DEPTH = 16;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data [N-1:0];
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             force_en;
  logic [SEL_W-1:0] force_sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic [SEL_W-1:0] out_src;
  logic             out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  // ---------------- source channels / scoreboard ----------------
  logic [WIDTH-1:0] ch_data [N][DEPTH];
  logic             ch_last [N][DEPTH];
  int               ch_len [N];
  int               ch_rd [N];

  logic [BW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            stall_q = 1'b0;
  logic [BW-1:0] stall_beat;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_chans();
    for (int i = 0; i < N; i++) begin
      ch_len[i] = 0;
      ch_rd[i]  = 0;
    end
  endtask

  task automatic push_ch(input int ch, input logic [WIDTH-1:0] d, input logic l);
    ch_data[ch][ch_len[ch]] = d;
    ch_last[ch][ch_len[ch]] = l;
    ch_len[ch]++;
  endtask

  task automatic expect_beat(input int src, input logic [WIDTH-1:0] d, input logic l);
    exp_q.push_back({SEL_W'(src), l, d});
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (ch_rd[i] < ch_len[i]) begin
        in_valid[i] = 1'b1;
        in_data[i]  = ch_data[i][ch_rd[i]];
        in_last[i]  = ch_last[i][ch_rd[i]];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i]  = '0;
        in_last[i]  = 1'b0;
      end
    end
  endtask

  // One clock: sample handshakes and the output on the falling edge,
  // advance the sources after the rising edge.
  task automatic tick(output bit beat);
    logic [N-1:0]  fire;
    logic [BW-1:0] cur;
    @(negedge clk);
    fire = in_valid & in_ready;
    cur  = {out_src, out_last, out_data};
    beat = out_valid && out_ready;
    if (stall_q && !rst) check_eq("hold", cur, stall_beat);
    stall_q    = out_valid && !out_ready && !rst;
    stall_beat = cur;
    if (beat) begin
      if (exp_q.size() == 0) check_eq("extra_beat", 1, 0);
      else check_eq("beat", cur, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) ch_rd[i]++;
    drive_inputs();
    #1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    bit b;
    int c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      tick(b);
      c++;
    end
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit           b;
    int           cnt;
    int           p;
    logic [N-1:0] consumed;
    logic [WIDTH-1:0] d;

    rst       = 1'b1;
    out_ready = 1'b1;
    force_en  = 1'b0;
    force_sel = '0;
    clear_chans();

    // Round robin: every channel valid at reset release, ch0 has two beats.
    for (int ch = 0; ch < N; ch++) push_ch(ch, 64'h100 + 64'(ch), 1'b1);
    push_ch(0, 64'h1F0, 1'b1);
    for (int k = 0; k < N; k++) expect_beat(k, 64'h100 + 64'(k), 1'b1);
    expect_beat(0, 64'h1F0, 1'b1);
    drive_inputs();
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_src", out_src, 0);
    check_eq("rst_in_ready", in_ready, 0);
    tick(b);
    tick(b);
    check_eq("rst_hold_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    check_eq("rr_first_ready", in_ready, 8'h01);
    tick(b);
    check_eq("rr_latency", b, 0);
    for (int k = 0; k < N + 1; k++) begin
      tick(b);
      check_eq("rr_stream", b, 1);
    end
    check_eq("rr_done", exp_q.size(), 0);

    // Backpressure on ch3 (pointer now 1).
    clear_chans();
    for (int k = 0; k < 4; k++) begin
      push_ch(3, 64'hA0 + 64'(k), 1'b1);
      expect_beat(3, 64'hA0 + 64'(k), 1'b1);
    end
    drive_inputs();
    tick(b);
    tick(b);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(b);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_hold_data", out_data, 64'hA1);
      check_eq("bp_ready3", in_ready[3], 0);
    end
    out_ready = 1'b1;
    drain("bp_drain", 50);

    // Packet lock: ch2 4-beat packet, ch5 valid one cycle later (ptr 4).
    clear_chans();
    for (int k = 0; k < 4; k++) push_ch(2, 64'h20 + 64'(k), (k == 3));
    expect_beat(2, 64'h20, 1'b0);
    if (LOCK) begin
      expect_beat(2, 64'h21, 1'b0);
      expect_beat(2, 64'h22, 1'b0);
      expect_beat(2, 64'h23, 1'b1);
      expect_beat(5, 64'h50, 1'b1);
      expect_beat(5, 64'h51, 1'b1);
    end else begin
      expect_beat(5, 64'h50, 1'b1);
      expect_beat(2, 64'h21, 1'b0);
      expect_beat(5, 64'h51, 1'b1);
      expect_beat(2, 64'h22, 1'b0);
      expect_beat(2, 64'h23, 1'b1);
    end
    drive_inputs();
    tick(b);
    push_ch(5, 64'h50, 1'b1);
    push_ch(5, 64'h51, 1'b1);
    drive_inputs();
    drain("lock_drain", 50);

    // Force mode on ch6 with every channel valid.
    clear_chans();
    force_en  = 1'b1;
    force_sel = 3'd6;
    for (int ch = 0; ch < N; ch++) if (ch != 6) push_ch(ch, 64'h4000 + 64'(ch), 1'b1);
    for (int k = 0; k < 3; k++) begin
      push_ch(6, 64'h4600 + 64'(k), 1'b1);
      expect_beat(6, 64'h4600 + 64'(k), 1'b1);
    end
    drive_inputs();
    #1;
    check_eq("force_ready", in_ready, 8'h40);
    drain("force_drain", 50);
    tick(b);
    check_eq("force_out_dropped", out_valid, 0);
    check_eq("force_no_grant", in_ready, 0);
    consumed = '0;
    for (int ch = 0; ch < N; ch++) if (ch != 6 && ch_rd[ch] != 0) consumed[ch] = 1'b1;
    check_eq("force_others_idle", consumed, 0);
    force_en = 1'b0;
    p = LOCK ? 6 : 3;
    for (int k = 0; k < N; k++) begin
      int ch;
      ch = (p + k) % N;
      if (ch != 6) expect_beat(ch, 64'h4000 + 64'(ch), 1'b1);
    end
    drain("force_release", 50);

    // Reset in the middle of a ch1 packet with a stalled output beat.
    clear_chans();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_ch(1, 64'h1100 + 64'(k), (k == 2));
    drive_inputs();
    tick(b);
    check_eq("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_data", out_data, 0);
    check_eq("rst_mid_ready", in_ready, 0);
    exp_q.delete();
    clear_chans();
    stall_q = 1'b0;
    drive_inputs();
    tick(b);
    rst       = 1'b0;
    out_ready = 1'b1;
    push_ch(1, 64'h11, 1'b1);
    push_ch(4, 64'h44, 1'b1);
    expect_beat(1, 64'h11, 1'b1);
    expect_beat(4, 64'h44, 1'b1);
    drive_inputs();
    #1;
    check_eq("rst_release_ready", in_ready, 8'h02);
    drain("rst_drain", 50);

    // Idle drain: single beat on ch7 (ptr 5), then pointer wraps to 0.
    clear_chans();
    push_ch(7, 64'h55, 1'b1);
    expect_beat(7, 64'h55, 1'b1);
    drive_inputs();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick(b);
      cnt += int'(b);
    end
    check_eq("idle_one_beat", cnt, 1);
    check_eq("idle_valid_low", out_valid, 0);
    check_eq("idle_q_empty", exp_q.size(), 0);
    clear_chans();
    push_ch(0, 64'h0A, 1'b1);
    push_ch(7, 64'h7A, 1'b1);
    expect_beat(0, 64'h0A, 1'b1);
    expect_beat(7, 64'h7A, 1'b1);
    drive_inputs();
    drain("wrap_drain", 50);

    // Random backpressure over three full rotations (ptr 0).
    clear_chans();
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < N; ch++) begin
        d = {$urandom, $urandom};
        push_ch(ch, d, 1'b1);
        expect_beat(ch, d, 1'b1);
      end
    end
    drive_inputs();
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      tick(b);
      cnt++;
    end
    out_ready = 1'b1;
    drain("rand_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
